stream_eot_fifo: RTL and testbench

- First-word-fall-through FIFO for TAPA/HLS-style streams whose MSB is the end-of-transfer (close) flag.
- Sits directly downstream of a kernel stream output such as VecAdd's c_s. It takes the producer's din/full_n/write handshake and presents dout/empty_n/read to the next consumer.
- Tracks transfer length: counts data tokens between close tokens and reports the completed length when a close token leaves the FIFO.

---
 rtl/stream_eot_fifo.sv | 136 +++++++++++++
 tb/tb_stream_eot_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_eot_fifo.sv
// rtl/stream_eot_fifo.sv - first-word-fall-through FIFO with end-of-transfer length tracking
//
// Purpose: buffers a producer stream whose MSB is a close (end-of-transfer) flag,
// presents the head token FWFT-style, and reports the data-token count of each
// completed transfer when its close token is read out.
//
// Ports:
//   ap_clk      clock, rising edge
//   ap_rst      synchronous active-high reset
//   if_din      write token from producer
//   if_full_n   high when an entry is free
//   if_write    producer write strobe
//   if_dout     head token, valid when if_empty_n=1
//   if_empty_n  high when at least one token is stored
//   if_read     consumer read strobe
//   occupancy   current entry count
//   eot_pulse   one-cycle pulse after a close token is read
//   last_len    data-token count of the most recently completed transfer
module stream_eot_fifo #(
    parameter int DATA_WIDTH = 33,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [DATA_WIDTH-1:0]      if_din,
    output logic                       if_full_n,
    input  logic                       if_write,
    output logic [DATA_WIDTH-1:0]      if_dout,
    output logic                       if_empty_n,
    input  logic                       if_read,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       eot_pulse,
    output logic [CNT_WIDTH-1:0]       last_len
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]         count_q, count_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic [CNT_WIDTH-1:0]  token_cnt_q, token_cnt_d;
    logic [CNT_WIDTH-1:0]  last_len_q, last_len_d;
    logic                  eot_q, eot_d;

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] head;
    logic                  head_close;

    // Handshake acceptance uses only the registered flags, so the producer and
    // consumer never see a combinational path through the other side.
    assign wr_en      = if_write && full_n_q;
    assign rd_en      = if_read && empty_n_q;
    assign head       = mem_q[rd_ptr_q];
    assign head_close = head[DATA_WIDTH-1];

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        token_cnt_d = token_cnt_q;
        last_len_d  = last_len_q;
        eot_d       = 1'b0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (rd_en) begin
            if (head_close) begin
                last_len_d  = token_cnt_q;
                token_cnt_d = '0;
                eot_d       = 1'b1;
            end else if (token_cnt_q != CNT_MAX) begin
                token_cnt_d = token_cnt_q + 1'b1;
            end
        end

        // Flags are registered copies of the next count, so they track count
        // exactly one edge later with no same-cycle dependence on the strobes.
        full_n_d  = (count_d != DEPTH_C);
        empty_n_d = (count_d != '0);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            full_n_q    <= 1'b1;
            empty_n_q   <= 1'b0;
            token_cnt_q <= '0;
            last_len_q  <= '0;
            eot_q       <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= if_din;
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            full_n_q    <= full_n_d;
            empty_n_q   <= empty_n_d;
            token_cnt_q <= token_cnt_d;
            last_len_q  <= last_len_d;
            eot_q       <= eot_d;
        end
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign if_dout    = head;
    assign occupancy  = count_q;
    assign eot_pulse  = eot_q;
    assign last_len   = last_len_q;

endmodule

// File: tb/tb_stream_eot_fifo.sv
// tb/tb_stream_eot_fifo.sv - self-checking bench for stream_eot_fifo
module tb_stream_eot_fifo;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic [32:0] if_din;
    logic        if_full_n;
    logic        if_write;
    logic [32:0] if_dout;
    logic        if_empty_n;
    logic        if_read;
    logic [2:0]  occupancy;
    logic        eot_pulse;
    logic [31:0] last_len;

    int tests = 0;
    int fails = 0;

    stream_eot_fifo #(.DATA_WIDTH(33), .DEPTH(4), .CNT_WIDTH(32)) dut (
        .ap_clk     (clk),
        .ap_rst     (ap_rst),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_write   (if_write),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .if_read    (if_read),
        .occupancy  (occupancy),
        .eot_pulse  (eot_pulse),
        .last_len   (last_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [32:0] din;
        logic        r;
        logic        chk_dout;
        logic [32:0] dout;
        logic        empty_n;
        logic        full_n;
        logic [2:0]  occ;
        logic        eot;
        logic [31:0] len;
    } vec_t;

    vec_t tv [13];

    function automatic vec_t mk(input logic w, input logic [32:0] din, input logic r,
                                input logic cd, input logic [32:0] dout, input logic en,
                                input logic fn, input logic [2:0] occ, input logic eot,
                                input logic [31:0] len);
        vec_t v;
        v.w = w; v.din = din; v.r = r; v.chk_dout = cd; v.dout = dout;
        v.empty_n = en; v.full_n = fn; v.occ = occ; v.eot = eot; v.len = len;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later, release strobes.
    task automatic step(input logic w, input logic [32:0] din, input logic r);
        if_write = w;
        if_din   = din;
        if_read  = r;
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
    endtask

    task automatic do_reset(input logic w);
        ap_rst = 1'b1;
        step(w, 33'h0_12345678, w);
        ap_rst = 1'b0;
    endtask

    localparam logic [32:0] CLOSE = 33'h1_00000000;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst   = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;

        // Fill past depth with the read strobe low, then drain while the held-off
        // producer retries its last data token and the close token.
        tv[0]  = mk(1, 33'h0_3F800000, 0, 1, 33'h0_3F800000, 1, 1, 3'd1, 0, 0);
        tv[1]  = mk(1, 33'h0_40400000, 0, 1, 33'h0_3F800000, 1, 1, 3'd2, 0, 0);
        tv[2]  = mk(1, 33'h0_40A00000, 0, 1, 33'h0_3F800000, 1, 1, 3'd3, 0, 0);
        tv[3]  = mk(1, 33'h0_40E00000, 0, 1, 33'h0_3F800000, 1, 0, 3'd4, 0, 0);
        tv[4]  = mk(1, 33'h0_41100000, 0, 1, 33'h0_3F800000, 1, 0, 3'd4, 0, 0);
        tv[5]  = mk(1, CLOSE,          0, 1, 33'h0_3F800000, 1, 0, 3'd4, 0, 0);
        tv[6]  = mk(1, 33'h0_41100000, 1, 1, 33'h0_40400000, 1, 1, 3'd3, 0, 0);
        tv[7]  = mk(1, 33'h0_41100000, 1, 1, 33'h0_40A00000, 1, 1, 3'd3, 0, 0);
        tv[8]  = mk(1, CLOSE,          1, 1, 33'h0_40E00000, 1, 1, 3'd3, 0, 0);
        tv[9]  = mk(0, 33'h0,          1, 1, 33'h0_41100000, 1, 1, 3'd2, 0, 0);
        tv[10] = mk(0, 33'h0,          1, 1, CLOSE,          1, 1, 3'd1, 0, 0);
        tv[11] = mk(0, 33'h0,          1, 0, 33'h0,          0, 1, 3'd0, 1, 5);
        tv[12] = mk(0, 33'h0,          0, 0, 33'h0,          0, 1, 3'd0, 0, 5);

        do_reset(1'b1);
        chk("reset empty_n", 64'(if_empty_n), 64'd0);
        chk("reset full_n",  64'(if_full_n),  64'd1);
        chk("reset dout",    64'(if_dout),    64'd0);
        chk("reset occ",     64'(occupancy),  64'd0);
        chk("reset eot",     64'(eot_pulse),  64'd0);
        chk("reset len",     64'(last_len),   64'd0);

        for (int i = 0; i < 13; i++) begin
            step(tv[i].w, tv[i].din, tv[i].r);
            if (tv[i].chk_dout)
                chk($sformatf("vec%0d dout", i), 64'(if_dout), 64'(tv[i].dout));
            chk($sformatf("vec%0d empty_n", i), 64'(if_empty_n), 64'(tv[i].empty_n));
            chk($sformatf("vec%0d full_n", i),  64'(if_full_n),  64'(tv[i].full_n));
            chk($sformatf("vec%0d occ", i),     64'(occupancy),  64'(tv[i].occ));
            chk($sformatf("vec%0d eot", i),     64'(eot_pulse),  64'(tv[i].eot));
            chk($sformatf("vec%0d len", i),     64'(last_len),   64'(tv[i].len));
        end

        // Reset mid-transfer with occupancy 3 and a non-zero last_len.
        step(1, 33'h0_00000011, 0);
        step(1, 33'h0_00000022, 0);
        step(1, 33'h0_00000033, 0);
        chk("pre-rst occ", 64'(occupancy), 64'd3);
        do_reset(1'b1);
        chk("rst mid empty_n", 64'(if_empty_n), 64'd0);
        chk("rst mid full_n",  64'(if_full_n),  64'd1);
        chk("rst mid len",     64'(last_len),   64'd0);
        chk("rst mid occ",     64'(occupancy),  64'd0);
        step(1, 33'h0_00000001, 0);
        step(1, 33'h0_00000002, 0);
        step(1, CLOSE, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("post-rst token cnt not stale", 64'(eot_pulse), 64'd0);
        step(0, 0, 1);
        chk("post-rst eot", 64'(eot_pulse), 64'd1);
        chk("post-rst len", 64'(last_len),  64'd2);

        // Write-to-read latency on an empty FIFO.
        do_reset(1'b0);
        step(1, 33'h0_3F800000, 0);
        chk("lat empty_n", 64'(if_empty_n), 64'd1);
        chk("lat dout",    64'(if_dout),    64'h0_3F800000);
        step(0, 0, 1);
        chk("lat drained empty_n", 64'(if_empty_n), 64'd0);

        // Read and write together while full: only the read happens.
        for (int i = 1; i <= 4; i++) step(1, 33'(i), 0);
        step(1, 33'h0_DEADBEEF, 1);
        chk("full rw occ", 64'(occupancy), 64'd3);
        for (int i = 2; i <= 4; i++) begin
            chk($sformatf("full drain %0d", i), 64'(if_dout), 64'(i));
            step(0, 0, 1);
        end
        chk("full drain empty", 64'(if_empty_n), 64'd0);
        chk("full drain occ",   64'(occupancy),  64'd0);

        // Steady streaming at occupancy 2 across pointer wrap.
        step(1, 33'd100, 0);
        step(1, 33'd101, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stream dout %0d", i), 64'(if_dout), 64'(100 + i));
            step(1, 33'(102 + i), 1);
            chk($sformatf("stream occ %0d", i), 64'(occupancy), 64'd2);
        end
        chk("stream tail0", 64'(if_dout), 64'd110);
        step(0, 0, 1);
        chk("stream tail1", 64'(if_dout), 64'd111);
        step(0, 0, 1);
        chk("stream empty", 64'(if_empty_n), 64'd0);

        // Read while empty, write while full: no state change.
        step(0, 0, 1);
        chk("rd empty occ", 64'(occupancy), 64'd0);
        chk("rd empty eot", 64'(eot_pulse), 64'd0);
        for (int i = 0; i < 4; i++) step(1, 33'(200 + i), 0);
        step(1, CLOSE, 0);
        chk("wr full occ",  64'(occupancy), 64'd4);
        chk("wr full dout", 64'(if_dout),   64'd200);
        chk("wr full eot",  64'(eot_pulse), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr full drain %0d", i), 64'(if_dout), 64'(200 + i));
            step(0, 0, 1);
        end
        chk("wr full no close", 64'(eot_pulse), 64'd0);

        // Two transfers: 3 data + close, then zero-length closes back to back.
        do_reset(1'b0);
        step(1, 33'h0_00000AAA, 0);
        step(1, 33'h0_00000BBB, 0);
        step(1, 33'h0_00000CCC, 0);
        step(1, 33'h1_0000ABCD, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("xfer1 close payload", 64'(if_dout), 64'h1_0000ABCD);
        step(0, 0, 1);
        chk("xfer1 eot", 64'(eot_pulse), 64'd1);
        chk("xfer1 len", 64'(last_len),  64'd3);
        step(1, CLOSE, 0);
        chk("xfer1 eot one cycle", 64'(eot_pulse), 64'd0);
        step(1, CLOSE, 0);
        step(0, 0, 1);
        chk("xfer2 eot", 64'(eot_pulse), 64'd1);
        chk("xfer2 len", 64'(last_len),  64'd0);
        step(0, 0, 1);
        chk("xfer3 eot b2b", 64'(eot_pulse), 64'd1);
        chk("xfer3 len",     64'(last_len),  64'd0);
        step(0, 0, 0);
        chk("xfer3 eot drop", 64'(eot_pulse), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
